// File: rtl/adc_spi_defs.sv
// Frame-layout definitions shared by both ends of the LTC1407A-style ADC SPI link.
package adc_spi_defs;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam int DATA_W_DEF = 14;
  localparam int GAP_DEF    = 2;

  function automatic int frame_len(input int gap, input int dw);
    return 3 * gap + 2 * dw;
  endfunction

  localparam int FRAME_LEN = frame_len(GAP_DEF, DATA_W_DEF);
endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with rise/fall pulses on the synchronized level.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sr;
  logic              prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr   <= '0;
      prev <= 1'b0;
    end else begin
      sr   <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  end

  assign rise = sr[STAGES-1] & ~prev;
  assign fall = ~sr[STAGES-1] & prev;
endmodule

// File: rtl/adc_spi_responder.sv
// LTC1407A-style dual-channel ADC SPI responder.
// Define ADC_RESP_HIZ_EN to tri-state spi_miso during gap positions.
module adc_spi_responder
  import adc_spi_defs::*;
#(
  parameter int DATA_W      = 14,
  parameter int GAP_CYCLES  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              ad_conv,
  input  logic [DATA_W-1:0] ch0_sample,
  input  logic [DATA_W-1:0] ch1_sample,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              busy,
  output logic              frame_done
);
  localparam int FLEN = frame_len(GAP_CYCLES, DATA_W);

  localparam logic [5:0] K_LAST = 6'(FLEN - 1);
  localparam logic [5:0] C0_LO  = 6'(GAP_CYCLES);
  localparam logic [5:0] C0_HI  = 6'(GAP_CYCLES + DATA_W);
  localparam logic [5:0] C1_LO  = 6'(2 * GAP_CYCLES + DATA_W);
  localparam logic [5:0] C1_HI  = 6'(2 * GAP_CYCLES + 2 * DATA_W);

  state_t            state;
  logic [5:0]        k;
  logic [DATA_W-1:0] sh0;
  logic [DATA_W-1:0] sh1;

  logic sck_fall;
  logic conv_rise;
  logic sck_rise_unused;
  logic conv_fall_unused;
  logic in_ch0;
  logic in_ch1;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (spi_sck),
    .rise (sck_rise_unused),
    .fall (sck_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_conv_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (ad_conv),
    .rise (conv_rise),
    .fall (conv_fall_unused)
  );

  assign in_ch0 = (k >= C0_LO) && (k < C0_HI);
  assign in_ch1 = (k >= C1_LO) && (k < C1_HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      k          <= '0;
      sh0        <= '0;
      sh1        <= '0;
      spi_miso   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (conv_rise) begin
        sh0      <= ch0_sample;
        sh1      <= ch1_sample;
        k        <= '0;
        state    <= ST_SHIFT;
        busy     <= 1'b1;
        spi_miso <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            spi_miso <= 1'b0;
          end
          ST_SHIFT: begin
            if (sck_fall) begin
              k <= k + 6'd1;
              unique case (1'b1)
                in_ch0: begin
                  spi_miso <= sh0[DATA_W-1];
                  sh0      <= {sh0[DATA_W-2:0], 1'b0};
                end
                in_ch1: begin
                  spi_miso <= sh1[DATA_W-1];
                  sh1      <= {sh1[DATA_W-2:0], 1'b0};
                end
                default: spi_miso <= 1'b0;
              endcase
              if (k == K_LAST) begin
                state      <= ST_DONE;
                frame_done <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            k        <= '0;
            spi_miso <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef ADC_RESP_HIZ_EN
  logic oe_q;

  // Enable follows the position being presented, so it tracks spi_miso.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oe_q <= 1'b0;
    end else if (conv_rise) begin
      oe_q <= 1'b0;
    end else if (state == ST_SHIFT) begin
      if (sck_fall) begin
        oe_q <= in_ch0 | in_ch1;
      end
    end else begin
      oe_q <= 1'b0;
    end
  end

  assign spi_miso_oe = oe_q;
`else
  assign spi_miso_oe = 1'b1;
`endif
endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboard bench for adc_spi_responder: master-side capture on spi_sck rise.
module tb_adc_spi_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spi_sck = 1'b1;
  logic        ad_conv = 1'b0;
  logic [13:0] ch0_sample = '0;
  logic [13:0] ch1_sample = '0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        busy;
  logic        frame_done;

  typedef struct packed {
    logic miso;
    logic oe;
    int   pos;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;
  logic cap_en = 1'b0;

  adc_spi_responder dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sck     (spi_sck),
    .ad_conv     (ad_conv),
    .ch0_sample  (ch0_sample),
    .ch1_sample  (ch1_sample),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #10 clk = ~clk;

`ifdef ADC_RESP_HIZ_EN
  localparam logic OE_RST = 1'b0;
`else
  localparam logic OE_RST = 1'b1;
`endif

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic oe_at(input int i);
`ifdef ADC_RESP_HIZ_EN
    return !(i < 2 || i == 16 || i == 17 || i >= 32);
`else
    return 1'b1;
`endif
  endfunction

  task automatic push_bits(input logic [33:0] v, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.miso = v[33-i];
      e.oe   = oe_at(i);
      e.pos  = i;
      exp_q.push_back(e);
    end
  endtask

  always @(posedge spi_sck) begin
    if (cap_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL capture underflow got bit %0b want none", spi_miso);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("bit_k%0d", e.pos), {62'd0, spi_miso, spi_miso_oe},
            {62'd0, e.miso, e.oe});
      end
    end
  end

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic sck_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) spi_sck = 1'b0;
      repeat (4) @(negedge clk);
      spi_sck = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic start_frame(input logic [13:0] c0, input logic [13:0] c1);
    int t;
    ch0_sample = c0;
    ch1_sample = c1;
    @(negedge clk) ad_conv = 1'b1;
    repeat (3) @(negedge clk);
    ad_conv = 1'b0;
    t = 0;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("busy_rise", {63'd0, busy}, 64'd1);
  endtask

  task automatic finish_frame(input int fd_exp);
    repeat (10) @(negedge clk);
    chk("frame_done_cnt", 64'(fd_cnt), 64'(fd_exp));
    chk("busy_after", {63'd0, busy}, 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_miso"}, {63'd0, spi_miso}, 64'd0);
    chk({tag, "_oe"}, {63'd0, spi_miso_oe}, {63'd0, OE_RST});
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, frame_done}, 64'd0);
  endtask

  logic [33:0] basic_v;
  logic [33:0] v;

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    basic_v = 34'b00_10101100111011_00_11001010101100_00;

    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #40 spi_sck = ~spi_sck;
    end
    spi_sck = 1'b1;
    #1 chk_reset_outs("reset");
    @(negedge clk) rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      sck_cycles(1);
      if (i % 5 == 0) begin
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_miso", {63'd0, spi_miso}, 64'd0);
      end
    end
    chk("idle_done_cnt", 64'(fd_cnt), 64'd0);

    cap_en = 1'b1;
    start_frame(14'h2B3B, 14'h32AC);
    @(negedge clk) ch0_sample = 14'h0000;
    push_bits(basic_v, 34);
    sck_cycles(34);
    finish_frame(1);

    start_frame(14'h1555, 14'h0AAA);
    v = {2'b00, 14'h1555, 2'b00, 14'h0AAA, 2'b00};
    push_bits(v, 10);
    sck_cycles(10);
    start_frame(14'h3FFF, 14'h0001);
    v = {2'b00, 14'h3FFF, 2'b00, 14'h0001, 2'b00};
    push_bits(v, 34);
    sck_cycles(34);
    finish_frame(2);

    start_frame(14'h2001, 14'h1FFE);
    v = {2'b00, 14'h2001, 2'b00, 14'h1FFE, 2'b00};
    push_bits(v, 20);
    sck_cycles(20);
    cap_en = 1'b0;
    @(negedge clk) rst = 1'b0;
    #1 chk_reset_outs("midrst");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_q", 64'(exp_q.size()), 64'd0);

    cap_en = 1'b1;
    start_frame(14'h0F0F, 14'h30C3);
    v = {2'b00, 14'h0F0F, 2'b00, 14'h30C3, 2'b00};
    push_bits(v, 34);
    sck_cycles(34);
    finish_frame(3);
    cap_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
